// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered, handshaked ALU-control decoder.
// Decodes OpALU/funct/opcode into an ALU operation code, flags unrecognised
// ops, and holds mult/div for MULDIV_LAT cycles before presenting the code.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | nothing held; ready to accept
//   ST_HOLD   | out_valid=1, outputs stable until out_ready
//   ST_MULDIV | mult/div in flight, latency counter running
module alu_control_pipe #(
  parameter int CTRL_W     = 4,
  parameter int FUNCT_W    = 6,
  parameter int MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         OpALU,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [FUNCT_W-1:0] opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  inputALU,
  output logic               illegal,
  output logic               muldiv_start,
  output logic               busy
);

  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_MULDIV = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       code_q, code_d;
  logic             illegal_q, illegal_d;
  logic             muldiv_start_q, muldiv_start_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_muldiv;
  logic             accept;

  // in_ready only looks at state and out_ready, never at the upstream side
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Decode the op fields; bits above [5:0] must be zero for a legal op
  always_comb begin
    dec_code    = 4'b0000;
    dec_illegal = 1'b0;
    dec_muldiv  = 1'b0;
    case (OpALU)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0110;
      2'b10: begin
        if ((funct >> 6) != '0) begin
          dec_illegal = 1'b1;
        end else begin
          case (funct[5:0])
            6'b100000: dec_code = 4'b0010;
            6'b100010: dec_code = 4'b0110;
            6'b100100: dec_code = 4'b0000;
            6'b100101: dec_code = 4'b0001;
            6'b101010: dec_code = 4'b0111;
            6'b100110: dec_code = 4'b0011;
            6'b100111: dec_code = 4'b1100;
            6'b000000: dec_code = 4'b1000;
            6'b000010: dec_code = 4'b1001;
            6'b011000: begin dec_code = 4'b1010; dec_muldiv = 1'b1; end
            6'b011010: begin dec_code = 4'b1011; dec_muldiv = 1'b1; end
            default:   dec_illegal = 1'b1;
          endcase
        end
      end
      default: begin
        if ((opcode >> 6) != '0) begin
          dec_illegal = 1'b1;
        end else begin
          case (opcode[5:0])
            6'b001000: dec_code = 4'b0010;
            6'b001100: dec_code = 4'b0000;
            6'b001101: dec_code = 4'b0001;
            6'b001010: dec_code = 4'b0111;
            6'b001110: dec_code = 4'b0011;
            default:   dec_illegal = 1'b1;
          endcase
        end
      end
    endcase
  end

  // Next-state and registered-output logic for the handshake/sequencer
  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    code_d         = code_q;
    illegal_d      = illegal_q;
    muldiv_start_d = 1'b0;
    busy_d         = busy_q;
    cnt_d          = cnt_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          code_d    = dec_code;
          illegal_d = dec_illegal;
          if (dec_muldiv) begin
            state_d        = ST_MULDIV;
            out_valid_d    = 1'b0;
            muldiv_start_d = 1'b1;
            busy_d         = 1'b1;
            cnt_d          = CNT_LOAD;
          end else begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_MULDIV: begin
        if (cnt_q == '0) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      out_valid_q    <= 1'b0;
      code_q         <= 4'b0000;
      illegal_q      <= 1'b0;
      muldiv_start_q <= 1'b0;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      code_q         <= code_d;
      illegal_q      <= illegal_d;
      muldiv_start_q <= muldiv_start_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign inputALU     = CTRL_W'(code_q);
  assign illegal      = illegal_q;
  assign muldiv_start = muldiv_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_alu_control_pipe;

  localparam int CTRL_W     = 4;
  localparam int FUNCT_W    = 8;
  localparam int MULDIV_LAT = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         OpALU;
  logic [FUNCT_W-1:0] funct;
  logic [FUNCT_W-1:0] opcode;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  inputALU;
  logic               illegal;
  logic               muldiv_start;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;

  alu_control_pipe #(
    .CTRL_W(CTRL_W), .FUNCT_W(FUNCT_W), .MULDIV_LAT(MULDIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .OpALU(OpALU), .funct(funct), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .inputALU(inputALU), .illegal(illegal),
    .muldiv_start(muldiv_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [3:0] code, input logic ill);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " inputALU"}, 32'(inputALU), 32'(code));
    chk({tag, " illegal"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    OpALU     = 2'b00;
    funct     = '0;
    opcode    = '0;
    out_ready = 1'b1;
    step(); step();
    chk_out("reset", 1'b0, 4'b0000, 1'b0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset muldiv_start", 32'(muldiv_start), 32'd0);
    rst_n = 1'b1;
    #1 chk("post-reset in_ready", 32'(in_ready), 32'd1);

    // single add, latency 1, then drains
    step();
    in_valid = 1'b1; OpALU = 2'b10; funct = 8'b0010_0000;
    step();
    in_valid = 1'b0;
    chk_out("add", 1'b1, 4'b0010, 1'b0);
    step();
    chk("add drain out_valid", 32'(out_valid), 32'd0);

    // I-type back-to-back stream
    in_valid = 1'b1; OpALU = 2'b11; opcode = 8'b0000_1101;
    step();
    chk_out("ori", 1'b1, 4'b0001, 1'b0);
    chk("ori in_ready", 32'(in_ready), 32'd1);
    opcode = 8'b0000_1010;
    step();
    chk_out("slti", 1'b1, 4'b0111, 1'b0);
    chk("slti in_ready", 32'(in_ready), 32'd1);
    opcode = 8'b0000_1110;
    step();
    chk_out("xori", 1'b1, 4'b0011, 1'b0);
    in_valid = 1'b0;
    step();
    chk("stream drain out_valid", 32'(out_valid), 32'd0);

    // div with MULDIV_LAT=4
    in_valid = 1'b1; OpALU = 2'b10; funct = 8'b0001_1010;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= MULDIV_LAT; k++) begin
      chk($sformatf("div c%0d muldiv_start", k), 32'(muldiv_start), (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("div c%0d busy", k), 32'(busy), 32'd1);
      chk($sformatf("div c%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("div c%0d out_valid", k), 32'(out_valid), 32'd0);
      in_valid = 1'b1; funct = 8'b0010_0000;
      step();
      in_valid = 1'b0;
    end
    chk_out("div result", 1'b1, 4'b1011, 1'b0);
    chk("div result busy", 32'(busy), 32'd0);

    // illegal funct accepted back-to-back from HOLD, then branch
    in_valid = 1'b1; OpALU = 2'b10; funct = 8'b0011_1111;
    step();
    chk_out("illegal funct", 1'b1, 4'b0000, 1'b1);
    OpALU = 2'b01;
    step();
    chk_out("branch", 1'b1, 4'b0110, 1'b0);
    in_valid = 1'b0;
    step();
    chk("branch drain out_valid", 32'(out_valid), 32'd0);

    // nor held under backpressure while inputs toggle
    out_ready = 1'b0;
    in_valid = 1'b1; OpALU = 2'b10; funct = 8'b0010_0111;
    step();
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("nor hold%0d", k), 1'b1, 4'b1100, 1'b0);
      chk($sformatf("nor hold%0d in_ready", k), 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      funct = (k % 2 == 0) ? 8'b0010_0000 : 8'b0001_1000;
      step();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; funct = 8'b0010_0010;
    #1 chk("nor release in_ready", 32'(in_ready), 32'd1);
    step();
    chk_out("sub after hold", 1'b1, 4'b0110, 1'b0);
    in_valid = 1'b0;
    step();

    // high funct bits make an otherwise valid add illegal; load ignores funct
    in_valid = 1'b1; OpALU = 2'b10; funct = 8'b0110_0000;
    step();
    chk_out("high-bit funct", 1'b1, 4'b0000, 1'b1);
    OpALU = 2'b00; funct = 8'hFF;
    step();
    chk_out("load", 1'b1, 4'b0010, 1'b0);
    in_valid = 1'b0;
    step();

    // reset in the middle of a mult discards it
    in_valid = 1'b1; OpALU = 2'b10; funct = 8'b0001_1000;
    step();
    in_valid = 1'b0;
    chk("mult muldiv_start", 32'(muldiv_start), 32'd1);
    chk("mult busy", 32'(busy), 32'd1);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk_out("mid-mult reset", 1'b0, 4'b0000, 1'b0);
    chk("mid-mult reset busy", 32'(busy), 32'd0);
    chk("mid-mult reset muldiv_start", 32'(muldiv_start), 32'd0);
    step();
    rst_n = 1'b1;
    #1 chk("after reset in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < MULDIV_LAT + 2; k++) begin
      step();
      chk($sformatf("no stale c%0d out_valid", k), 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
